store_buffer: RTL

- Posted-write buffer between the CPU execute stage and the data memory.
- Stores are queued and drained in order into the single-port, write-on-clock data memory whenever no load needs the port.
- Loads read the memory combinationally and are forwarded from the youngest matching buffered store.
- Lets stores retire in one cycle without stalling loads.

---
 rtl/store_buffer_if.sv | 36 +++
 rtl/store_buffer.sv | 104 ++++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// Bundle of the CPU store/load handshake and data-memory port signals for store_buffer.
// The master side is the CPU plus data memory; the slave side is the buffer itself.
interface store_buffer_if #(
    parameter int addresswidth = 32,
    parameter int width        = 32,
    parameter int DEPTH        = 4,
    parameter int PTRW         = $clog2(DEPTH)
);
    logic                    st_valid;
    logic [addresswidth-1:0] st_addr;
    logic [width-1:0]        st_data;
    logic                    st_ready;
    logic                    ld_valid;
    logic [addresswidth-1:0] ld_addr;
    logic [width-1:0]        ld_data;
    logic                    ld_fwd;
    logic [addresswidth-1:0] mem_address;
    logic                    mem_writeEnable;
    logic [width-1:0]        mem_dataIn;
    logic [width-1:0]        mem_dataOut;
    logic [PTRW:0]           count;
    logic                    empty;
    logic                    full;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_dataOut,
        input  st_ready, ld_data, ld_fwd, mem_address, mem_writeEnable, mem_dataIn,
               count, empty, full
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_dataOut,
        output st_ready, ld_data, ld_fwd, mem_address, mem_writeEnable, mem_dataIn,
               count, empty, full
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between execute stage and data memory, with youngest-match load forwarding.
// Optional in-place merging of repeated stores to the youngest entry: define STORE_COALESCE_EN.
module store_buffer #(
    parameter int addresswidth = 32,
    parameter int width        = 32,
    parameter int DEPTH        = 4,
    parameter int PTRW         = $clog2(DEPTH)
) (
    input logic           clk,
    input logic           reset,
    store_buffer_if.slave bus
);
    logic [addresswidth-1:0] addr_q [DEPTH];
    logic [width-1:0]        data_q [DEPTH];
    logic [PTRW-1:0]         head;
    logic [PTRW-1:0]         tail;
    logic [PTRW-1:0]         young;
    logic [PTRW:0]           cnt;

    logic                    empty_w;
    logic                    full_w;
    logic                    drain;
    logic                    coal;
    logic                    accept;
    logic                    alloc;
    logic                    fwd_hit;
    logic [width-1:0]        fwd_data;

    assign empty_w = (cnt == '0);
    assign full_w  = (cnt == (PTRW+1)'(DEPTH));
    assign drain   = !bus.ld_valid && !empty_w;
    assign young   = tail - PTRW'(1);

`ifdef STORE_COALESCE_EN
    // A lone entry that is leaving this cycle cannot absorb the store.
    assign coal         = bus.st_valid && !empty_w && (bus.st_addr == addr_q[young])
                          && !(drain && cnt == (PTRW+1)'(1));
    assign bus.st_ready = !full_w || coal;
`else
    assign coal         = 1'b0;
    assign bus.st_ready = !full_w;
`endif

    assign accept = bus.st_valid && bus.st_ready;
    assign alloc  = accept && !coal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (drain) head <= head + PTRW'(1);
            if (alloc) tail <= tail + PTRW'(1);
            case ({alloc, drain})
                2'b10:   cnt <= cnt + (PTRW+1)'(1);
                2'b01:   cnt <= cnt - (PTRW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage carries no reset; validity is defined solely by head/count.
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_q[tail] <= bus.st_addr;
            data_q[tail] <= bus.st_data;
        end else if (coal) begin
            data_q[young] <= bus.st_data;
        end
    end

    // Scan oldest to youngest so the last hit is the youngest matching store.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (((PTRW+1)'(i) < cnt) && (addr_q[head + PTRW'(i)] == bus.ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[head + PTRW'(i)];
            end
        end
    end

    assign bus.ld_fwd  = bus.ld_valid && fwd_hit;
    assign bus.ld_data = fwd_hit ? fwd_data : bus.mem_dataOut;

    always_comb begin
        bus.mem_address     = '0;
        bus.mem_dataIn      = '0;
        bus.mem_writeEnable = 1'b0;
        if (bus.ld_valid) begin
            bus.mem_address = bus.ld_addr;
        end else if (!empty_w) begin
            bus.mem_address     = addr_q[head];
            bus.mem_dataIn      = data_q[head];
            bus.mem_writeEnable = 1'b1;
        end
    end

    assign bus.count = cnt;
    assign bus.empty = empty_w;
    assign bus.full  = full_w;
endmodule
